// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Lets NUM_REQ message sources share one UART transmitter. Ownership is
// granted round-robin for one whole message. Each byte is forwarded to the
// UART as a one-cycle tx_start pulse. A quiet gap of GAP_CYCLES clocks is
// enforced after every message so the receiver can re-frame.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a per-byte stall counter aborts the message with an
//   err_timeout pulse after TIMEOUT_CYCLES clocks without a valid byte.
//   When undefined, SEND waits indefinitely and err_timeout stays 0.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-low
//   req          level request per source, held for the whole message
//   req_valid    byte available from source i
//   req_data     byte of source i at [8i+7:8i]
//   req_last     marks req_data as the final byte of the message
//   req_ready    combinational: grant[i] while in SEND
//   grant        registered one-hot grant, all-zero with no owner
//   sel          registered index of the current or last owner
//   tx_data      registered byte to the UART
//   tx_start     registered one-cycle launch pulse
//   tx_busy      UART busy (rises the cycle after tx_start)
//   busy         high in every state except IDLE
//   err_timeout  one-cycle pulse on a stall abort
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 8191,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] sel,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int          SEL_W    = $clog2(NUM_REQ);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 65536) begin : g_bad_gap
    $error("uart_tx_arbiter: GAP_CYCLES must be 1..65536");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be 1..65536");
  end

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEND  = 3'd1,
    ARM   = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [SEL_W-1:0]   rr_ptr_r, rr_ptr_s;
  logic [SEL_W-1:0]   pick_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [SEL_W-1:0]   sel_s;
  logic [7:0]         tx_data_s;
  logic               tx_start_s;
  logic               last_r, last_s;
  logic [15:0]        gap_cnt_r, gap_cnt_s;
  logic               err_s;
`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]        stall_cnt_r, stall_cnt_s;
`endif

  // First set request at or above ptr, searching upward with wrap-around.
  // Iterating from the farthest offset down leaves the nearest hit in win.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] win;
    int               idx;
    win = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (r[idx]) begin
        win = SEL_W'(idx);
      end
    end
    return win;
  endfunction

  assign pick_s    = rr_pick(req, rr_ptr_r);
  assign req_ready = (state_r == SEND) ? grant : {NUM_REQ{1'b0}};
  assign busy      = (state_r != IDLE);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s    = state_r;
    rr_ptr_s   = rr_ptr_r;
    grant_s    = grant;
    sel_s      = sel;
    tx_data_s  = tx_data;
    tx_start_s = 1'b0;
    last_s     = last_r;
    gap_cnt_s  = gap_cnt_r;
    err_s      = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    stall_cnt_s = 16'd0;
`endif
    case (state_r)
      IDLE: begin
        if (|req) begin
          state_s = SEND;
          sel_s   = pick_s;
          grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (!req[sel]) begin
          // Owner withdrew mid-message: abort without sending.
          state_s   = GAP;
          grant_s   = {NUM_REQ{1'b0}};
          gap_cnt_s = 16'd0;
        end else if (req_valid[sel]) begin
          state_s    = ARM;
          tx_data_s  = req_data[{sel, 3'b000} +: 8];
          tx_start_s = 1'b1;
          last_s     = req_last[sel];
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (stall_cnt_r == TO_LAST) begin
          state_s   = GAP;
          grant_s   = {NUM_REQ{1'b0}};
          gap_cnt_s = 16'd0;
          err_s     = 1'b1;
        end else begin
          stall_cnt_s = stall_cnt_r + 16'd1;
        end
`else
        else begin
          state_s = SEND;
        end
`endif
      end
      ARM: begin
        // tx_busy only rises the cycle after tx_start, so it is not sampled here.
        state_s = DRAIN;
      end
      DRAIN: begin
        if (!tx_busy) begin
          if (last_r) begin
            state_s   = GAP;
            grant_s   = {NUM_REQ{1'b0}};
            gap_cnt_s = 16'd0;
          end else begin
            state_s = SEND;
          end
        end else begin
          state_s = DRAIN;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s  = IDLE;
          rr_ptr_s = (sel == SEL_W'(NUM_REQ - 1)) ? {SEL_W{1'b0}} : sel + 1'b1;
        end else begin
          gap_cnt_s = gap_cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= {SEL_W{1'b0}};
      grant       <= {NUM_REQ{1'b0}};
      sel         <= {SEL_W{1'b0}};
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      last_r      <= 1'b0;
      gap_cnt_r   <= 16'd0;
      err_timeout <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_r <= 16'd0;
`endif
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      grant       <= grant_s;
      sel         <= sel_s;
      tx_data     <= tx_data_s;
      tx_start    <= tx_start_s;
      last_r      <= last_s;
      gap_cnt_r   <= gap_cnt_s;
      err_timeout <= err_s;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt_r <= stall_cnt_s;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed-vector bench for uart_tx_arbiter (NUM_REQ=4, GAP_CYCLES=8,
// TIMEOUT_CYCLES=20). A small UART model holds tx_busy high for 10 clocks
// starting the cycle after each tx_start. Expected cycle counts:
//   request -> tx_start                 : 2 clocks
//   tx_start -> next byte, same message : 13 clocks
//   tx_start -> next message's tx_start : GAP_CYCLES + 14 clocks
// Honours UART_ARB_TIMEOUT_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 8;
  localparam int TOUT = 20;

  logic        clk;
  logic        reset;
  logic [3:0]  req, req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic [1:0]  sel;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy, busy, err_timeout;

  int n_vec  = 0;
  int n_miss = 0;
  int uart_cnt = 0;

  uart_tx_arbiter #(
    .NUM_REQ       (NREQ),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .grant      (grant),
    .sel        (sel),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model: busy for 10 clocks beginning the cycle after tx_start.
  always @(posedge clk) begin
    if (tx_start) uart_cnt <= 10;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end
  assign tx_busy = (uart_cnt != 0);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req = 4'h0; req_valid = 4'h0; req_last = 4'h0; req_data = 32'h0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic wait_start(input string tag, output int cycles);
    cycles = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      cycles++;
      if (tx_start) return;
    end
    check_val({tag, "_no_start"}, 32'(tx_start), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick();
    end
    check_val({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_ready(input string tag, input logic [3:0] exp);
    for (int i = 0; i < 300; i++) begin
      if (req_ready == exp) break;
      tick();
    end
    check_val({tag, "_ready"}, 32'(req_ready), 32'(exp));
  endtask

  int cyc;
  int n_starts;

  initial begin
    clear_inputs();
    reset = 1'b0;

    // 1: reset held 3 clocks with all requests up
    req = 4'hF; req_valid = 4'hF;
    repeat (3) tick();
    check_val("rst_grant",    32'(grant),       32'h0);
    check_val("rst_sel",      32'(sel),         32'h0);
    check_val("rst_tx_data",  32'(tx_data),     32'h0);
    check_val("rst_tx_start", 32'(tx_start),    32'h0);
    check_val("rst_busy",     32'(busy),        32'h0);
    check_val("rst_err",      32'(err_timeout), 32'h0);
    check_val("rst_ready",    32'(req_ready),   32'h0);
    clear_inputs();
    reset = 1'b1;
    tick();
    check_val("idle_no_req_busy", 32'(busy), 32'h0);

    // 2: single source, two-byte message
    req = 4'b0001; req_valid = 4'b0001; req_data = 32'h0000_0041; req_last = 4'b0000;
    wait_start("s1_b0", cyc);
    check_val("s1_b0_latency", 32'(cyc),     32'd2);
    check_val("s1_b0_data",    32'(tx_data), 32'h41);
    check_val("s1_b0_grant",   32'(grant),   32'h1);
    check_val("s1_b0_busy",    32'(busy),    32'h1);
    req_data = 32'h0000_0042; req_last = 4'b0001;
    wait_start("s1_b1", cyc);
    check_val("s1_b1_spacing", 32'(cyc),     32'd13);
    check_val("s1_b1_data",    32'(tx_data), 32'h42);
    clear_inputs();
    repeat (12) tick();
    check_val("s1_gap_grant", 32'(grant), 32'h0);
    check_val("s1_gap_busy",  32'(busy),  32'h1);
    repeat (GAP - 1) tick();
    check_val("s1_gap_end_busy", 32'(busy), 32'h1);
    tick();
    check_val("s1_idle_busy", 32'(busy), 32'h0);
    check_val("s1_sel_held",  32'(sel),  32'h0);

    // 3: round-robin with all four requesting single-byte messages
    do_reset();
    req = 4'hF; req_valid = 4'hF; req_last = 4'hF; req_data = 32'hA3A2_A1A0;
    for (int i = 0; i < 5; i++) begin
      wait_start("rr", cyc);
      check_val($sformatf("rr%0d_data", i),  32'(tx_data), 32'hA0 + 32'(i % 4));
      check_val($sformatf("rr%0d_grant", i), 32'(grant),   32'h1 << (i % 4));
      check_val($sformatf("rr%0d_cyc", i),   32'(cyc),     (i == 0) ? 32'd2 : 32'(GAP + 14));
    end
    clear_inputs();
    wait_idle("rr");

    // 4: source 2 aborts after the first of three bytes
    do_reset();
    req = 4'b0100; req_valid = 4'b0100; req_data = 32'h0011_0000;
    wait_start("ab_b0", cyc);
    check_val("ab_b0_data",  32'(tx_data), 32'h11);
    check_val("ab_b0_grant", 32'(grant),   32'h4);
    req_valid = 4'b0000; req_data = 32'h0022_0000;
    wait_ready("ab", 4'b0100);
    req = 4'b0000;
    tick();
    check_val("ab_grant",    32'(grant),    32'h0);
    check_val("ab_tx_start", 32'(tx_start), 32'h0);
    check_val("ab_busy",     32'(busy),     32'h1);
    n_starts = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      tick();
      n_starts += int'(tx_start);
    end
    check_val("ab_idle",      32'(busy),     32'h0);
    check_val("ab_no_starts", 32'(n_starts), 32'h0);
    // rr_ptr is now 3: with 0 and 3 requesting, 3 must win
    req = 4'b1001; req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'hD300_00D0;
    wait_start("ab_rr", cyc);
    check_val("ab_rr_data",  32'(tx_data), 32'hD3);
    check_val("ab_rr_grant", 32'(grant),   32'h8);
    check_val("ab_rr_sel",   32'(sel),     32'h3);
    clear_inputs();
    wait_idle("ab_rr");

    // 5: reset while draining a frame
    do_reset();
    req = 4'b0001; req_valid = 4'b0001; req_last = 4'b0001; req_data = 32'h0000_0055;
    wait_start("md", cyc);
    clear_inputs();
    repeat (3) tick();
    check_val("md_busy_before", 32'(busy), 32'h1);
    reset = 1'b0;
    tick();
    check_val("md_grant",    32'(grant),    32'h0);
    check_val("md_busy",     32'(busy),     32'h0);
    check_val("md_tx_start", 32'(tx_start), 32'h0);
    check_val("md_tx_data",  32'(tx_data),  32'h0);
    reset = 1'b1;
    repeat (15) tick();

    // 6: granted source never presents a byte
    do_reset();
    req = 4'b0010;
    wait_ready("to", 4'b0010);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (TOUT) tick();
    check_val("to_err",   32'(err_timeout), 32'h1);
    check_val("to_grant", 32'(grant),       32'h0);
    check_val("to_busy",  32'(busy),        32'h1);
    tick();
    check_val("to_err_pulse", 32'(err_timeout), 32'h0);
`else
    repeat (100) tick();
    check_val("to_grant_held", 32'(grant),       32'h2);
    check_val("to_ready_held", 32'(req_ready),   32'h2);
    check_val("to_err_zero",   32'(err_timeout), 32'h0);
    check_val("to_no_start",   32'(tx_start),    32'h0);
`endif
    clear_inputs();
    wait_idle("to");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
